// File: rtl/cgra_config_receiver.sv
// Tile-side config bus receiver: filters writes addressed to this tile, buffers them
// in a small FIFO drained over valid/ready, and flags completion after a bus idle run.
module cgra_config_receiver #(
    parameter logic [15:0] TILE_ID          = 16'h0015,
    parameter int          FIFO_DEPTH       = 4,
    parameter int          IDLE_DONE_CYCLES = 4
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic [31:0] config_addr_in,
    input  logic [31:0] config_data_in,
    output logic        cfg_valid_out,
    input  logic        cfg_ready_in,
    output logic [7:0]  cfg_feature_out,
    output logic [7:0]  cfg_reg_out,
    output logic [31:0] cfg_data_out,
    output logic        config_done_out,
    output logic        overflow_out,
    output logic [15:0] write_count_out
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int IW = $clog2(IDLE_DONE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Entry layout: {register id, feature id, data}
    logic [47:0]   mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    state_t        state_r;
    logic [IW-1:0] idle_cnt_r;

    logic          addr_zero_s;
    logic          match_s;
    logic          pop_s;
    logic          push_s;
    logic          full_s;
    logic [PW-1:0] count_s;
    logic [PW-1:0] wr_ptr_nxt_s;
    logic [PW-1:0] rd_ptr_nxt_s;
    logic [PW-1:0] count_nxt_s;
    logic [AW-1:0] rd_idx_nxt_s;
    logic [47:0]   new_entry_s;
    logic [47:0]   head_nxt_s;
    logic [IW-1:0] idle_inc_s;

    // FIFO next-state and next head entry, with bypass when the head is written this edge.
    always_comb begin
        addr_zero_s  = (config_addr_in == 32'h0000_0000);
        match_s      = !addr_zero_s && (config_addr_in[15:0] == TILE_ID);
        pop_s        = cfg_valid_out && cfg_ready_in;
        count_s      = wr_ptr_r - rd_ptr_r;
        full_s       = (count_s == PW'(FIFO_DEPTH));
        push_s       = match_s && (!full_s || pop_s);
        wr_ptr_nxt_s = wr_ptr_r + {{(PW-1){1'b0}}, push_s};
        rd_ptr_nxt_s = rd_ptr_r + {{(PW-1){1'b0}}, pop_s};
        count_nxt_s  = wr_ptr_nxt_s - rd_ptr_nxt_s;
        rd_idx_nxt_s = rd_ptr_nxt_s[AW-1:0];
        new_entry_s  = {config_addr_in[31:16], config_data_in};
        if (push_s && (rd_idx_nxt_s == wr_ptr_r[AW-1:0])) begin
            head_nxt_s = new_entry_s;
        end else begin
            head_nxt_s = mem_r[rd_idx_nxt_s];
        end
        if (idle_cnt_r == IW'(IDLE_DONE_CYCLES)) begin
            idle_inc_s = idle_cnt_r;
        end else begin
            idle_inc_s = idle_cnt_r + {{(IW-1){1'b0}}, 1'b1};
        end
    end

    // FIFO storage, pointers, registered head outputs and sticky status.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 48'h0;
            end
            wr_ptr_r        <= {PW{1'b0}};
            rd_ptr_r        <= {PW{1'b0}};
            cfg_valid_out   <= 1'b0;
            cfg_feature_out <= 8'h00;
            cfg_reg_out     <= 8'h00;
            cfg_data_out    <= 32'h0000_0000;
            overflow_out    <= 1'b0;
            write_count_out <= 16'h0000;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= new_entry_s;
            end
            wr_ptr_r        <= wr_ptr_nxt_s;
            rd_ptr_r        <= rd_ptr_nxt_s;
            cfg_valid_out   <= (count_nxt_s != {PW{1'b0}});
            cfg_reg_out     <= head_nxt_s[47:40];
            cfg_feature_out <= head_nxt_s[39:32];
            cfg_data_out    <= head_nxt_s[31:0];
            if (match_s && !push_s) begin
                overflow_out <= 1'b1;
            end
            if (push_s && (write_count_out != 16'hFFFF)) begin
                write_count_out <= write_count_out + 16'h0001;
            end
        end
    end

    // Configuration-phase FSM; done is asserted together with entry into DONE.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_r         <= ST_IDLE;
            idle_cnt_r      <= {IW{1'b0}};
            config_done_out <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    idle_cnt_r <= {IW{1'b0}};
                    if (!addr_zero_s) begin
                        state_r <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (addr_zero_s) begin
                        idle_cnt_r <= idle_inc_s;
                        if ((idle_inc_s == IW'(IDLE_DONE_CYCLES)) &&
                            (count_nxt_s == {PW{1'b0}})) begin
                            state_r         <= ST_DONE;
                            config_done_out <= 1'b1;
                        end
                    end else begin
                        idle_cnt_r <= {IW{1'b0}};
                    end
                end
                ST_DONE: begin
                    if (!addr_zero_s) begin
                        state_r         <= ST_LOAD;
                        idle_cnt_r      <= {IW{1'b0}};
                        config_done_out <= 1'b0;
                    end
                end
                default: begin
                    state_r         <= ST_IDLE;
                    idle_cnt_r      <= {IW{1'b0}};
                    config_done_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cgra_config_receiver.sv
// Self-checking bench: directed scenarios plus randomized bus traffic, all checked
// against a queue-based reference model of the receiver.
module tb_cgra_config_receiver;

    localparam logic [15:0] TILE = 16'h0015;
    localparam int          DEPTH = 4;
    localparam int          IDLE_T = 4;

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b0;
    logic [31:0] config_addr_in = 32'h0;
    logic [31:0] config_data_in = 32'h0;
    logic        cfg_ready_in = 1'b0;
    logic        cfg_valid_out;
    logic [7:0]  cfg_feature_out;
    logic [7:0]  cfg_reg_out;
    logic [31:0] cfg_data_out;
    logic        config_done_out;
    logic        overflow_out;
    logic [15:0] write_count_out;

    cgra_config_receiver #(
        .TILE_ID(TILE), .FIFO_DEPTH(DEPTH), .IDLE_DONE_CYCLES(IDLE_T)
    ) dut (
        .clk_in(clk_in), .reset_in(reset_in),
        .config_addr_in(config_addr_in), .config_data_in(config_data_in),
        .cfg_valid_out(cfg_valid_out), .cfg_ready_in(cfg_ready_in),
        .cfg_feature_out(cfg_feature_out), .cfg_reg_out(cfg_reg_out),
        .cfg_data_out(cfg_data_out), .config_done_out(config_done_out),
        .overflow_out(overflow_out), .write_count_out(write_count_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: pending writes in arrival order, plus phase flags.
    logic [63:0] m_q[$];   // {addr, data}
    bit          m_started;
    bit          m_done;
    int          m_zeros;
    bit          m_ovf;
    int          m_wc;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_started = 1'b0;
        m_done    = 1'b0;
        m_zeros   = 0;
        m_ovf     = 1'b0;
        m_wc      = 0;
    endtask

    task automatic model_step(input logic [31:0] a, input logic [31:0] d, input bit r);
        bit is_match;
        bit do_pop;
        is_match = (a != 32'h0) && (a[15:0] == TILE);
        do_pop   = (m_q.size() > 0) && r;
        if (do_pop) void'(m_q.pop_front());
        if (is_match) begin
            if (m_q.size() < DEPTH) begin
                m_q.push_back({a, d});
                if (m_wc < 65535) m_wc++;
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (!m_started) begin
            if (a != 32'h0) begin
                m_started = 1'b1;
                m_zeros   = 0;
            end
        end else if (!m_done) begin
            if (a == 32'h0) begin
                if (m_zeros < IDLE_T) m_zeros++;
            end else begin
                m_zeros = 0;
            end
            if (m_zeros >= IDLE_T && m_q.size() == 0) m_done = 1'b1;
        end else if (a != 32'h0) begin
            m_done  = 1'b0;
            m_zeros = 0;
        end
    endtask

    task automatic compare_all();
        logic [63:0] h;
        check_eq("valid", {31'h0, cfg_valid_out}, {31'h0, m_q.size() > 0});
        if (m_q.size() > 0 && cfg_valid_out) begin
            h = m_q[0];
            check_eq("feature", {24'h0, cfg_feature_out}, {24'h0, h[55:48]});
            check_eq("reg", {24'h0, cfg_reg_out}, {24'h0, h[63:56]});
            check_eq("data", cfg_data_out, h[31:0]);
        end
        check_eq("done", {31'h0, config_done_out}, {31'h0, m_done});
        check_eq("overflow", {31'h0, overflow_out}, {31'h0, m_ovf});
        check_eq("write_count", {16'h0, write_count_out}, m_wc);
    endtask

    task automatic cycle(input logic [31:0] a, input logic [31:0] d, input bit r);
        config_addr_in = a;
        config_data_in = d;
        cfg_ready_in   = r;
        @(posedge clk_in);
        model_step(a, d, r);
        #1;
        compare_all();
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        #2;
        reset_in = 1'b0;
        #1;
        model_reset();
        check_eq("rst_valid", {31'h0, cfg_valid_out}, 32'h0);
        check_eq("rst_head", {cfg_feature_out, cfg_reg_out, 16'h0}, 32'h0);
        check_eq("rst_data", cfg_data_out, 32'h0);
        check_eq("rst_done", {31'h0, config_done_out}, 32'h0);
        check_eq("rst_ovf", {31'h0, overflow_out}, 32'h0);
        check_eq("rst_wc", {16'h0, write_count_out}, 32'h0);
        #2;
        reset_in = 1'b1;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] rnd;
        int sel;
        model_reset();
        #1;
        pulse_reset();

        // Single write, drained immediately.
        cycle(32'h0203_0015, 32'hDEAD_BEEF, 1'b1);
        check_eq("t1_valid", {31'h0, cfg_valid_out}, 32'h1);
        check_eq("t1_fields", {16'h0, cfg_reg_out, cfg_feature_out}, 32'h0000_0203);
        check_eq("t1_data", cfg_data_out, 32'hDEAD_BEEF);
        check_eq("t1_wc", {16'h0, write_count_out}, 32'h1);
        cycle(32'h0, 32'h0, 1'b1);
        check_eq("t1_drained", {31'h0, cfg_valid_out}, 32'h0);

        // Non-matching address then idle run declares done.
        pulse_reset();
        cycle(32'h0001_0016, 32'h1234_5678, 1'b1);
        for (int i = 0; i < 3; i++) cycle(32'h0, 32'h0, 1'b1);
        check_eq("t2_not_yet", {31'h0, config_done_out}, 32'h0);
        cycle(32'h0, 32'h0, 1'b1);
        check_eq("t2_done", {31'h0, config_done_out}, 32'h1);
        check_eq("t2_wc", {16'h0, write_count_out}, 32'h0);

        // Overflow with stalled sink, then drain in order.
        pulse_reset();
        for (int i = 0; i < 5; i++) cycle({8'(i), 8'(i + 16), TILE}, 32'hA000_0000 + 32'(i), 1'b0);
        check_eq("t3_ovf", {31'h0, overflow_out}, 32'h1);
        check_eq("t3_wc", {16'h0, write_count_out}, 32'h4);
        check_eq("t3_head", cfg_data_out, 32'hA000_0000);
        for (int i = 0; i < 4; i++) cycle(32'h0, 32'h0, 1'b1);
        check_eq("t3_empty", {31'h0, cfg_valid_out}, 32'h0);

        // Full FIFO with simultaneous pop accepts the write.
        pulse_reset();
        for (int i = 0; i < 4; i++) cycle({8'h01, 8'(i), TILE}, 32'hB000_0000 + 32'(i), 1'b0);
        cycle({8'h07, 8'h07, TILE}, 32'hB000_0004, 1'b1);
        check_eq("t4_ovf", {31'h0, overflow_out}, 32'h0);
        check_eq("t4_wc", {16'h0, write_count_out}, 32'h5);
        check_eq("t4_head", cfg_data_out, 32'hB000_0001);
        for (int i = 0; i < 5; i++) cycle(32'h0, 32'h0, 1'b1);

        // Done is held off until the FIFO drains, then cleared by new activity.
        pulse_reset();
        for (int i = 0; i < 3; i++) cycle({8'h02, 8'h05, TILE}, 32'(i), 1'b0);
        for (int i = 0; i < 10; i++) cycle(32'h0, 32'h0, 1'b0);
        check_eq("t5_held", {31'h0, config_done_out}, 32'h0);
        cycle(32'h0, 32'h0, 1'b1);
        cycle(32'h0, 32'h0, 1'b1);
        check_eq("t5_not_yet", {31'h0, config_done_out}, 32'h0);
        cycle(32'h0, 32'h0, 1'b1);
        check_eq("t5_done", {31'h0, config_done_out}, 32'h1);
        cycle(32'h0009_0001, 32'h0, 1'b1);
        check_eq("t5_cleared", {31'h0, config_done_out}, 32'h0);

        // Reset in the middle of loading discards everything.
        for (int i = 0; i < 3; i++) cycle({8'h03, 8'h03, TILE}, 32'(i), 1'b0);
        pulse_reset();
        for (int i = 0; i < 6; i++) cycle(32'h0, 32'h0, 1'b1);
        check_eq("t6_idle", {31'h0, config_done_out}, 32'h0);

        // Randomized traffic with periodic idle windows and rare resets.
        for (int n = 0; n < 3000; n++) begin
            rnd = $urandom;
            sel = $urandom_range(0, 9);
            if ((n % 120) >= 100 || sel < 4) begin
                a = 32'h0;
            end else if (sel < 8) begin
                a = {rnd[31:16], TILE};
            end else if (sel == 8) begin
                a = {rnd[31:16], TILE + 16'($urandom_range(1, 200))};
            end else begin
                a = {rnd[31:17], 1'b1, 16'h0000};
            end
            cycle(a, $urandom, ($urandom_range(0, 1) == 1));
            if ($urandom_range(0, 399) == 0) pulse_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
